// File: rtl/i2c_mpu_target_if.sv
// Register-side interface of the I2C MPU-6050 target.
// Carries the local (sensor-side) write port and the bus-write notification port.
//   loc_wr_en/addr/data : local register write strobe, address, data  (into target)
//   bus_wr_valid/addr/data : 1-clk pulse with address/data of a master write (out of target)
//   busy                : target FSM is not idle (out of target)
// Modports: master = sensor-side user of the target, slave = the target itself.
interface i2c_mpu_target_if #(
  parameter int unsigned REG_AW = 7
) ();
  logic              loc_wr_en;
  logic [REG_AW-1:0] loc_wr_addr;
  logic [7:0]        loc_wr_data;
  logic              bus_wr_valid;
  logic [REG_AW-1:0] bus_wr_addr;
  logic [7:0]        bus_wr_data;
  logic              busy;

  modport master (
    output loc_wr_en, loc_wr_addr, loc_wr_data,
    input  bus_wr_valid, bus_wr_addr, bus_wr_data, busy
  );

  modport slave (
    input  loc_wr_en, loc_wr_addr, loc_wr_data,
    output bus_wr_valid, bus_wr_addr, bus_wr_data, busy
  );
endinterface

// File: rtl/i2c_mpu_target.sv
// I2C target modelling the MPU-6050 register interface.
// Decodes START/Sr/STOP, matches a 7-bit device address, takes a register pointer, then serves
// burst writes and burst reads with pointer auto-increment.
// Ports:
//   clk    : main clock (must be >= 20x the SCL rate)
//   rst_n  : asynchronous active-low reset
//   scl    : I2C clock from the master, sampled only
//   sda    : I2C data, open-drain (driven 1'b0 or released to 1'bz)
//   reg_if : loc_wr_* local write port, bus_wr_* write notification, busy
// Build option:
//   I2C_TGT_PTR_WRAP_EN defined   -> pointer wraps from 2**REG_AW-1 to 0 on increment
//   I2C_TGT_PTR_WRAP_EN undefined -> pointer saturates at 2**REG_AW-1
module i2c_mpu_target #(
  parameter int unsigned CLK_MAIN     = 50000000,
  parameter logic [6:0]  DEV_ADDR     = 7'h68,
  parameter int unsigned REG_AW       = 7,
  parameter logic [7:0]  PWR_MGMT_RST = 8'h40
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               scl,
  inout  wire                sda,
  i2c_mpu_target_if.slave    reg_if
);

  localparam int unsigned          RegDepth = 2 ** REG_AW;
  localparam logic [REG_AW-1:0]    PtrMax   = {REG_AW{1'b1}};

  // Oversampling below 20x the 400 kHz maximum cannot resolve SCL/SDA ordering reliably.
  if (CLK_MAIN < 32'd8000000) begin : g_clk_chk
    $error("i2c_mpu_target: CLK_MAIN too low for 400 kHz SCL");
  end

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataAck,
    StWaitStop
  } state_e;

  state_e            state_q;
  logic [3:0]        bit_cnt_q;
  logic [7:0]        shift_q;
  logic              sda_oe_q;
  logic              ack_q;
  logic              rw_q;
  logic [REG_AW-1:0] ptr_q;
  logic              bus_wr_valid_q;
  logic [REG_AW-1:0] bus_wr_addr_q;
  logic [7:0]        bus_wr_data_q;
  logic [7:0]        regs_q [RegDepth];

  // ---------------------------------------------------------------------------
  // Input synchronisers: two sync stages plus one history stage per line.
  // Reset to 1 so the idle bus does not produce edges when reset is released.
  // ---------------------------------------------------------------------------
  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_hist_q, sda_hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl};
      sda_sync_q <= {sda_sync_q[0], sda};
      scl_hist_q <= scl_sync_q[1];
      sda_hist_q <= sda_sync_q[1];
    end
  end

  logic scl_s, sda_s;
  logic scl_rise, scl_fall, sda_rise, sda_fall;
  logic start_det, stop_det;

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_hist_q;
  assign scl_fall  = ~scl_s & scl_hist_q;
  assign sda_rise  = sda_s & ~sda_hist_q;
  assign sda_fall  = ~sda_s & sda_hist_q;
  // SCL must be high on both samples, otherwise the SDA edge is a normal data change.
  assign start_det = sda_fall & scl_s & scl_hist_q;
  assign stop_det  = sda_rise & scl_s & scl_hist_q;

  logic [7:0]        rx_byte;
  logic [7:0]        rd_byte;
  logic [REG_AW-1:0] ptr_inc;

  assign rx_byte = {shift_q[6:0], sda_s};
  assign rd_byte = regs_q[ptr_q];

`ifdef I2C_TGT_PTR_WRAP_EN
  assign ptr_inc = ptr_q + 1'b1;
`else
  assign ptr_inc = (ptr_q == PtrMax) ? ptr_q : ptr_q + 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Protocol FSM. Bits are sampled on SCL rise; SDA drive changes only on SCL fall.
  // In the *Ack states ack_q marks that the ACK low is already on the line, so the
  // following fall releases it and moves on. In StRdataAck ack_q records a master ACK.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      bit_cnt_q      <= 4'd0;
      shift_q        <= 8'h00;
      sda_oe_q       <= 1'b0;
      ack_q          <= 1'b0;
      rw_q           <= 1'b0;
      ptr_q          <= '0;
      bus_wr_valid_q <= 1'b0;
      bus_wr_addr_q  <= '0;
      bus_wr_data_q  <= 8'h00;
    end else begin
      bus_wr_valid_q <= 1'b0;
      if (start_det) begin
        state_q   <= StAddr;
        bit_cnt_q <= 4'd0;
        sda_oe_q  <= 1'b0;
        ack_q     <= 1'b0;
      end else if (stop_det) begin
        state_q   <= StIdle;
        bit_cnt_q <= 4'd0;
        sda_oe_q  <= 1'b0;
        ack_q     <= 1'b0;
      end else begin
        case (state_q)
          StIdle: ;

          StAddr: begin
            if (scl_rise) begin
              shift_q   <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q <= 4'd0;
                if (rx_byte[7:1] == DEV_ADDR) begin
                  rw_q    <= rx_byte[0];
                  state_q <= StAddrAck;
                end else begin
                  state_q <= StWaitStop;
                end
              end
            end
          end

          StPtr: begin
            if (scl_rise) begin
              shift_q   <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q <= 4'd0;
                ptr_q     <= rx_byte[REG_AW-1:0];
                state_q   <= StPtrAck;
              end
            end
          end

          StWdata: begin
            if (scl_rise) begin
              shift_q   <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              // Only a complete byte is committed; a STOP/Sr before this point drops it.
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q      <= 4'd0;
                bus_wr_valid_q <= 1'b1;
                bus_wr_addr_q  <= ptr_q;
                bus_wr_data_q  <= rx_byte;
                ptr_q          <= ptr_inc;
                state_q        <= StWdataAck;
              end
            end
          end

          StAddrAck, StPtrAck, StWdataAck: begin
            if (scl_fall) begin
              if (!ack_q) begin
                sda_oe_q <= 1'b1;
                ack_q    <= 1'b1;
              end else begin
                ack_q     <= 1'b0;
                bit_cnt_q <= 4'd0;
                if (state_q == StAddrAck && rw_q) begin
                  // Load the first read byte and present its MSB on this same fall.
                  shift_q  <= rd_byte;
                  sda_oe_q <= ~rd_byte[7];
                  ptr_q    <= ptr_inc;
                  state_q  <= StRdata;
                end else begin
                  sda_oe_q <= 1'b0;
                  state_q  <= (state_q == StAddrAck) ? StPtr : StWdata;
                end
              end
            end
          end

          StRdata: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= 4'd0;
                state_q   <= StRdataAck;
              end else begin
                shift_q  <= {shift_q[6:0], 1'b0};
                sda_oe_q <= ~shift_q[6];
              end
            end
          end

          StRdataAck: begin
            if (scl_rise) begin
              if (!sda_s) begin
                ack_q <= 1'b1;
              end else begin
                state_q <= StWaitStop;
              end
            end else if (scl_fall && ack_q) begin
              ack_q    <= 1'b0;
              shift_q  <= rd_byte;
              sda_oe_q <= ~rd_byte[7];
              ptr_q    <= ptr_inc;
              state_q  <= StRdata;
            end
          end

          StWaitStop: ;

          default: begin
            state_q  <= StIdle;
            sda_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register file. The bus write is applied in the cycle bus_wr_valid is high;
  // being the later assignment it wins over a local write to the same address.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RegDepth); i++) begin
        regs_q[i] <= (i == 'h6B) ? PWR_MGMT_RST : 8'h00;
      end
    end else begin
      if (reg_if.loc_wr_en) begin
        regs_q[reg_if.loc_wr_addr] <= reg_if.loc_wr_data;
      end
      if (bus_wr_valid_q) begin
        regs_q[bus_wr_addr_q] <= bus_wr_data_q;
      end
    end
  end

  assign sda                 = sda_oe_q ? 1'b0 : 1'bz;
  assign reg_if.bus_wr_valid = bus_wr_valid_q;
  assign reg_if.bus_wr_addr  = bus_wr_addr_q;
  assign reg_if.bus_wr_data  = bus_wr_data_q;
  assign reg_if.busy         = (state_q != StIdle);

endmodule

// File: tb/tb_i2c_mpu_target.sv
// Directed bench for i2c_mpu_target: a bit-banged I2C master drives the bus, expected read
// bytes and bus-write records go into scoreboard queues and are compared as the DUT produces them.
module tb_i2c_mpu_target;
  localparam int unsigned Q = 10;  // clocks per quarter SCL period

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl = 1'b1;
  logic m_sda_low = 1'b0;
  wire  sda;

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_mpu_target_if #(.REG_AW(7)) rif ();

  i2c_mpu_target #(
    .CLK_MAIN    (50000000),
    .DEV_ADDR    (7'h68),
    .REG_AW      (7),
    .PWR_MGMT_RST(8'h40)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .scl   (scl),
    .sda   (sda),
    .reg_if(rif.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int dut_low_cnt = 0;
  logic [14:0] got_wr[$];
  logic [14:0] exp_wr[$];
  logic [7:0]  exp_rd[$];

  always @(negedge clk) begin
    if (rif.bus_wr_valid) got_wr.push_back({rif.bus_wr_addr, rif.bus_wr_data});
    if (sda === 1'b0 && !m_sda_low) dut_low_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hq();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; hq();
    scl = 1'b1;       hq();
    m_sda_low = 1'b1; hq();
    scl = 1'b0;       hq();
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; hq();
    scl = 1'b1;       hq();
    m_sda_low = 1'b0; hq();
  endtask

  task automatic send_bit(input logic b);
    m_sda_low = ~b; hq();
    scl = 1'b1;     hq(); hq();
    scl = 1'b0;     hq();
  endtask

  task automatic recv_bit(output logic b);
    m_sda_low = 1'b0; hq();
    scl = 1'b1;       hq();
    b = sda;          hq();
    scl = 1'b0;       hq();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(input logic ack_it, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(~ack_it);
  endtask

  // Read n bytes; set_ptr selects a pointer write + Sr first. Expected bytes come from exp_rd.
  task automatic read_regs(input string tag, input logic set_ptr, input logic [7:0] addr,
                           input int n);
    logic ack;
    logic [7:0] d;
    i2c_start();
    if (set_ptr) begin
      write_byte(8'hD0, ack);
      write_byte(addr, ack);
      i2c_start();
    end
    write_byte(8'hD1, ack);
    check({tag, "_ack"}, {31'd0, ack}, 32'd1);
    for (int i = 0; i < n; i++) begin
      read_byte(i != n - 1, d);
      check($sformatf("%s_b%0d", tag, i), {24'd0, d},
            {24'd0, (exp_rd.size() > 0) ? exp_rd.pop_front() : 8'hxx});
    end
    i2c_stop();
  endtask

  task automatic check_writes(input string tag);
    logic [14:0] e, g;
    int k = 0;
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      g = (got_wr.size() > 0) ? got_wr.pop_front() : 15'h7fff;
      check($sformatf("%s_wr%0d", tag, k), {17'd0, g}, {17'd0, e});
      k++;
    end
    check({tag, "_wr_extra"}, got_wr.size(), 32'd0);
    got_wr.delete();
  endtask

  task automatic loc_wr(input logic [6:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    rif.loc_wr_en = 1'b1; rif.loc_wr_addr = a; rif.loc_wr_data = d;
    @(posedge clk); #1;
    rif.loc_wr_en = 1'b0;
  endtask

  initial begin
    logic ack0, ack1, ack2;
    int low_before;
    rif.loc_wr_en = 1'b0;
    rif.loc_wr_addr = '0;
    rif.loc_wr_data = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, rif.busy}, 32'd0);
    check("rst_valid", {31'd0, rif.bus_wr_valid}, 32'd0);
    check("rst_addr", {25'd0, rif.bus_wr_addr}, 32'd0);
    check("rst_data", {24'd0, rif.bus_wr_data}, 32'd0);
    check("rst_sda", {31'd0, sda}, 32'd1);
    rst_n = 1'b1;
    hq();

    // Address miss: no drive, no write
    low_before = dut_low_cnt;
    i2c_start();
    write_byte(8'hD2, ack0);
    write_byte(8'h6B, ack1);
    write_byte(8'h55, ack2);
    i2c_stop();
    check("miss_ack", {29'd0, ack0, ack1, ack2}, 32'd0);
    check("miss_drive", dut_low_cnt - low_before, 32'd0);
    check_writes("miss");
    exp_rd.push_back(8'h40);
    read_regs("miss_rd", 1'b1, 8'h6B, 1);

    // Abort after 4 data bits
    i2c_start();
    write_byte(8'hD0, ack0);
    write_byte(8'h6B, ack1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    i2c_stop();
    hq();
    check("abort_busy", {31'd0, rif.busy}, 32'd0);
    check_writes("abort");
    exp_rd.push_back(8'h40);
    read_regs("abort_rd", 1'b1, 8'h6B, 1);

    // Init write D0 6B 00
    i2c_start();
    write_byte(8'hD0, ack0);
    write_byte(8'h6B, ack1);
    exp_wr.push_back({7'h6B, 8'h00});
    write_byte(8'h00, ack2);
    i2c_stop();
    hq();
    check("init_acks", {29'd0, ack0, ack1, ack2}, 32'd7);
    check("init_busy", {31'd0, rif.busy}, 32'd0);
    check_writes("init");
    exp_rd.push_back(8'h00);
    read_regs("init_rd", 1'b1, 8'h6B, 1);

    // Burst read of 14 preloaded bytes, then pointer continues at 0x49
    for (int i = 0; i < 14; i++) loc_wr(7'h3B + 7'(i), 8'h10 + 8'(i));
    loc_wr(7'h49, 8'hA5);
    for (int i = 0; i < 14; i++) exp_rd.push_back(8'h10 + 8'(i));
    read_regs("burst", 1'b1, 8'h3B, 14);
    exp_rd.push_back(8'hA5);
    read_regs("ptr49", 1'b0, 8'h00, 1);

    // Pointer end-of-range behaviour
    i2c_start();
    write_byte(8'hD0, ack0);
    write_byte(8'h7F, ack1);
    exp_wr.push_back({7'h7F, 8'hAA});
    write_byte(8'hAA, ack2);
`ifdef I2C_TGT_PTR_WRAP_EN
    exp_wr.push_back({7'h00, 8'hBB});
`else
    exp_wr.push_back({7'h7F, 8'hBB});
`endif
    write_byte(8'hBB, ack2);
    i2c_stop();
    check_writes("wrap");
`ifdef I2C_TGT_PTR_WRAP_EN
    exp_rd.push_back(8'hAA);
    read_regs("wrap7f", 1'b1, 8'h7F, 1);
    exp_rd.push_back(8'hBB);
    read_regs("wrap00", 1'b1, 8'h00, 1);
`else
    exp_rd.push_back(8'hBB);
    read_regs("sat7f", 1'b1, 8'h7F, 1);
    exp_rd.push_back(8'h00);
    read_regs("sat00", 1'b1, 8'h00, 1);
`endif

    // Reset while the target drives the MSB (0) of 0x3B = 0x10
    i2c_start();
    write_byte(8'hD0, ack0);
    write_byte(8'h3B, ack1);
    i2c_start();
    write_byte(8'hD1, ack2);
    check("mid_pre_drive", {31'd0, sda}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_sda", {31'd0, sda}, 32'd1);
    check("mid_rst_busy", {31'd0, rif.busy}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    hq();
    exp_rd.push_back(8'h40);
    read_regs("mid_rd6b", 1'b1, 8'h6B, 1);
    exp_rd.push_back(8'h00);
    read_regs("mid_rd3b", 1'b1, 8'h3B, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
